sample_buffer_ctrl: RTL and testbench
=====================================

// Module: sample_buffer_ctrl
// PURPOSE
// - Initiator side of the single-port FFT sample memory (MEM_SIZE x NUM_BITS, 1-cycle read latency).
// - Captures one frame of ADC samples into the memory, then reads it back in address order.
// - Streams the frame to the FFT stage over a valid/ready interface; sits between ADC front-end and FFT.
// PARAMETERS
// - NUM_BITS   10    sample width / memory data width
// - MEM_SIZE   2048  samples per frame (power of two)
// - ADDR_BITS  $clog2(MEM_SIZE)  memory address width (11 at default)
// PORTS
// - clk          in   1          single clock, all logic rising-edge
// - rst          in   1          asynchronous, active-high reset
// - start        in   1          begin a capture+drain frame; honoured only in IDLE
// - sample_valid in   1          ADC sample present this cycle
// - sample_data  in   NUM_BITS   ADC sample
// - mem_we       out  1          memory write enable
// - mem_addr     out  ADDR_BITS  memory address
// - mem_din      out  NUM_BITS   memory write data
// - mem_dout     in   NUM_BITS   memory read data, valid 1 cycle after address
// - out_valid    out  1          stream beat valid
// - out_data     out  NUM_BITS   stream data
// - out_last     out  1          marks beat for address MEM_SIZE-1
// - out_ready    in   1          FFT accepts beat
// - busy         out  1          high in CAPTURE or DRAIN
// - done         out  1          1-cycle pulse after the last beat handshake
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; counters 0; output buffer emptied; memory contents untouched.
// - FSM IDLE -> CAPTURE on start; CAPTURE -> DRAIN when the write at MEM_SIZE-1 occurs;
//   DRAIN -> IDLE on handshake of the out_last beat (done=1 next cycle).
// - CAPTURE: mem_we=sample_valid, mem_addr=wr_cnt, mem_din=sample_data, combinational from
//   inputs/count; wr_cnt increments per accepted sample; gaps in sample_valid are allowed.
// - IDLE/DRAIN: mem_we=0 always; sample_valid and sample_data ignored.
// - DRAIN: rd_cnt counts 0..MEM_SIZE-1; a read issues (mem_addr=rd_cnt) when
//   occ + inflight - pop < 2 and rd_cnt has not passed MEM_SIZE-1.
//   - occ = buffer occupancy; inflight = read issued last cycle; pop = out_valid & out_ready.
//   - Returned data lands in a 2-entry output FIFO 1 cycle later.
//   - Sustains 1 beat/cycle when out_ready=1; never drops or duplicates under backpressure.
// - Stream rules:
//   - out_valid/out_data/out_last are driven from registered FIFO head.
//   - While out_valid & !out_ready these hold stable.
//   - out_last travels with its data entry.
// - start while busy: ignored. start and rst together: rst wins.
// - rst mid-operation: immediate return to IDLE. A partially written frame is discarded; the next start rewrites from addr 0.
// - Counters are ADDR_BITS wide. Terminal detection uses ==MEM_SIZE-1 plus a done flag, so no wrap-around reissue.
// - busy=1 from the cycle after start through the cycle of the last handshake.
// STRUCTURE
// - Shared package afinador_pkg: NUM_BITS, MEM_SIZE, ADDR_BITS constants; typedef enum
//   logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN} buf_state_t; typedef logic [NUM_BITS-1:0] sample_t.
// - Sub-module sbuf_out_fifo: 2-entry FIFO {data,last}, push/pop/occ, async active-high rst.
// - Top holds FSM, wr/rd counters, inflight flag and credit logic; instantiates mem alongside in parent.
// TESTING (bench with MEM_SIZE=8 and the mem model)
// - Reset: assert rst mid-cycle -> all outputs 0 immediately, busy=0, out_valid=0.
// - Capture: start, samples 10..17 with sample_valid gapped 1-0-1 -> mem_we pulses addr 0..7 with 10..17; busy=1.
// - Full rate: out_ready=1 -> 8 consecutive beats 10..17, out_last on 17 only, done pulse next cycle.
// - Backpressure: out_ready pattern 1,0,0,1,0,1... -> order 10..17 preserved, data stable when stalled, no dup/drop.
// - Ignored inputs: start pulses during CAPTURE/DRAIN and sample_valid=1 during DRAIN -> no restart, mem_we stays 0.
// - Reset mid-DRAIN after 3 beats -> IDLE, FIFO empty; new start captures at addr 0 and drains 8 fresh beats.

Source files
------------

// File: rtl/afinador_pkg.sv
// Constants and types shared by the FFT sample buffer blocks.
package afinador_pkg;
    localparam int NUM_BITS  = 10;
    localparam int MEM_SIZE  = 2048;
    localparam int ADDR_BITS = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN} buf_state_t;
    typedef logic [NUM_BITS-1:0] sample_t;
endpackage

// File: rtl/sample_buffer_ctrl_fifo.sv
// Two-entry output FIFO carrying {data,last}; the head always sits in slot 0
// so the stream outputs come straight from registers.
module sbuf_out_fifo #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         head_last
);
    logic [W-1:0] data0, data1;
    logic         last0, last1;
    logic         pop_ok;

    assign pop_ok     = pop && (occ != 2'd0);
    assign head_valid = (occ != 2'd0);
    assign head_data  = data0;
    assign head_last  = last0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy unchanged, the queue shifts.
                    if (occ == 2'd1) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sample_buffer_ctrl.sv
// Captures one ADC frame into the sample memory, then streams it back in
// address order to the FFT over valid/ready with credit-based read issue.
module sample_buffer_ctrl import afinador_pkg::*; #(
    parameter int NUM_BITS  = afinador_pkg::NUM_BITS,
    parameter int MEM_SIZE  = afinador_pkg::MEM_SIZE,
    parameter int ADDR_BITS = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sample_valid,
    input  logic [NUM_BITS-1:0]  sample_data,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [NUM_BITS-1:0]  mem_din,
    input  logic [NUM_BITS-1:0]  mem_dout,
    output logic                 out_valid,
    output logic [NUM_BITS-1:0]  out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);

    buf_state_t           state;
    logic [ADDR_BITS-1:0] wr_cnt, rd_cnt;
    logic                 rd_done, inflight, inflight_last;
    logic [1:0]           occ;
    logic                 pop, issue, rd_at_last;

    assign pop        = out_valid & out_ready;
    assign rd_at_last = (rd_cnt == LAST_ADDR);
    // A read may issue only if the FIFO will still have room when its data returns.
    assign issue = (state == ST_DRAIN) && !rd_done &&
                   (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state)
            ST_CAPTURE: begin
                mem_we   = sample_valid;
                mem_addr = wr_cnt;
                mem_din  = sample_data;
            end
            ST_DRAIN: mem_addr = issue ? rd_cnt : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            rd_done       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && rd_at_last;
            if (issue) begin
                rd_cnt <= rd_cnt + ADDR_BITS'(1);
                if (rd_at_last) rd_done <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_CAPTURE;
                        busy   <= 1'b1;
                        wr_cnt <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        wr_cnt <= wr_cnt + ADDR_BITS'(1);
                        if (wr_cnt == LAST_ADDR) begin
                            state   <= ST_DRAIN;
                            rd_cnt  <= '0;
                            rd_done <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sbuf_out_fifo #(.W(NUM_BITS)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (mem_dout),
        .push_last  (inflight_last),
        .pop        (pop),
        .occ        (occ),
        .head_valid (out_valid),
        .head_data  (out_data),
        .head_last  (out_last)
    );
endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Directed bench for sample_buffer_ctrl with an 8-entry frame and a
// behavioural single-port memory with 1-cycle read latency.
module tb_sample_buffer_ctrl;
    localparam int NB = 10;
    localparam int MS = 8;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sample_valid = 1'b0;
    logic [NB-1:0] sample_data = '0;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [NB-1:0] mem_din;
    logic [NB-1:0] mem_dout;
    logic          out_valid;
    logic [NB-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    logic [NB-1:0] mem [MS];
    int total = 0;
    int bad   = 0;
    int span;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    sample_buffer_ctrl #(.NUM_BITS(NB), .MEM_SIZE(MS), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts at 1 time unit after a rising edge with the block idle.
    task automatic capture(input int base, input bit gapped);
        start = 1'b1;
        #1;
        chk("busy_in_start_cycle", busy, 0);
        tick();
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
        tick();
        for (int i = 0; i < MS; i++) begin
            sample_valid = 1'b1;
            sample_data  = NB'(base + i);
            start        = (i == 3);
            #1;
            chk("cap_we", mem_we, 1);
            chk("cap_addr", mem_addr, i);
            chk("cap_din", mem_din, base + i);
            tick();
            if (gapped && i < MS - 1) begin
                sample_valid = 1'b0;
                sample_data  = 10'h3ff;
                start        = 1'b0;
                #1;
                chk("cap_gap_we", mem_we, 0);
                tick();
            end
        end
        sample_valid = 1'b0;
        start        = 1'b0;
    endtask

    // Leaves time at 2 units after the edge that precedes the final handshake.
    task automatic drain(input int base, input int nbeats, input bit bp, output int span_o);
        bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int            n = 0;
        int            cyc = 0;
        int            first = 0;
        int            last = 0;
        bit            stalled = 1'b0;
        logic [NB-1:0] prev = '0;
        while (n < nbeats && cyc < 100) begin
            out_ready    = bp ? pat[cyc % 6] : 1'b1;
            sample_valid = 1'b1;
            sample_data  = 10'h3ff;
            start        = (cyc == 2);
            #1;
            chk("drain_we", mem_we, 0);
            chk("drain_busy", busy, 1);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev);
            end
            if (out_valid && out_ready) begin
                chk("beat_data", out_data, base + n);
                chk("beat_last", out_last, (n == MS - 1));
                if (n == 0) first = cyc;
                last = cyc;
                n++;
            end
            stalled = out_valid && !out_ready;
            prev    = out_data;
            if (n < nbeats) tick();
            cyc++;
        end
        chk("beat_count", n, nbeats);
        start        = 1'b0;
        sample_valid = 1'b0;
        span_o       = last - first;
    endtask

    task automatic check_done();
        tick();
        #1;
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        tick();
        #1;
        chk("done_cleared", done, 0);
        tick();
    endtask

    initial begin
        // Asynchronous reset asserted between edges.
        #3;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Gapped capture, then full-rate drain.
        capture(10, 1'b1);
        drain(10, MS, 1'b0, span);
        chk("full_rate_span", span, MS - 1);
        check_done();

        // Recapture and drain under backpressure.
        capture(10, 1'b0);
        drain(10, MS, 1'b1, span);
        check_done();

        // Reset after three beats of a drain.
        capture(20, 1'b0);
        drain(20, 3, 1'b0, span);
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_we", mem_we, 0);
        tick();
        rst = 1'b0;
        tick();
        capture(30, 1'b0);
        drain(30, MS, 1'b0, span);
        chk("fresh_span", span, MS - 1);
        check_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
